// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// alu_seq : multi-cycle handshaked integer ALU (iterative shifts, optional
//           shift-add multiply enabled by the ALU_MUL_EN macro)
// Revision: 1.0
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             zero,
  output logic             illegal
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [3:0]       op_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] diff, single_res, idle_res, a_step, iter_res, acc_step;
  logic             single_ok, slt, is_shift, is_mul, op_mul, go_busy;
  logic [SHW-1:0]   shamt;

  assign shamt    = SrcB[SHW-1:0];
  assign is_shift = (ALUControl == 4'b1000) || (ALUControl == 4'b1001) ||
                    (ALUControl == 4'b1010);
  assign go_busy  = is_mul || (is_shift && (shamt != '0));

  // Signed less-than: sign of A-B corrected by the subtraction overflow.
  assign diff = SrcA + ~SrcB + WIDTH'(1);
  assign slt  = diff[WIDTH-1] ^ ((SrcA[WIDTH-1] != SrcB[WIDTH-1]) &&
                                 (diff[WIDTH-1] != SrcA[WIDTH-1]));

  always_comb begin
    single_res = '0;
    single_ok  = 1'b1;
    case (ALUControl)
      4'b0000: single_res = SrcA + SrcB;
      4'b0001: single_res = diff;
      4'b0010: single_res = SrcA & SrcB;
      4'b0011: single_res = SrcA | SrcB;
      4'b0100: single_res = SrcA ^ SrcB;
      4'b0101: single_res = {{(WIDTH-1){1'b0}}, slt};
      4'b0110: single_res = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
      default: single_ok  = 1'b0;
    endcase
  end

  // A zero-distance shift completes straight from IDLE with A unchanged.
  assign idle_res = is_shift ? SrcA : single_res;

  always_comb begin
    case (op_q)
      4'b1001: a_step = {1'b0, a_q[WIDTH-1:1]};
      4'b1010: a_step = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
      default: a_step = {a_q[WIDTH-2:0], 1'b0};
    endcase
  end

  assign iter_res = op_mul ? acc_step : a_step;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] acc_q, b_q;

  assign is_mul   = (ALUControl == 4'b1100);
  assign op_mul   = (op_q == 4'b1100);
  assign acc_step = b_q[0] ? acc_q + a_q : acc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      b_q   <= '0;
    end else if (state == IDLE && in_valid) begin
      acc_q <= '0;
      b_q   <= SrcB;
    end else if (state == BUSY) begin
      acc_q <= acc_step;
      b_q   <= {1'b0, b_q[WIDTH-1:1]};
    end
  end
`else
  assign is_mul   = 1'b0;
  assign op_mul   = 1'b0;
  assign acc_step = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = go_busy ? BUSY : DONE;
      end
      BUSY: if (cnt_q <= CW'(1)) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q       <= '0;
      op_q      <= '0;
      cnt_q     <= '0;
      ALUResult <= '0;
      zero      <= 1'b1;
      illegal   <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_q   <= SrcA;
      op_q  <= ALUControl;
      cnt_q <= is_mul ? CW'(WIDTH) : CW'(shamt);
      if (!go_busy) begin
        ALUResult <= idle_res;
        zero      <= (idle_res == '0);
        illegal   <= !(single_ok || is_shift);
      end
    end else if (state == BUSY) begin
      a_q   <= a_step;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q <= CW'(1)) begin
        ALUResult <= iter_res;
        zero      <= (iter_res == '0);
        illegal   <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// tb_alu_seq : directed self-checking bench for alu_seq (WIDTH = 32)
// Revision: 1.0
// ============================================================================
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready, zero, illegal;
  logic [31:0] SrcA, SrcB, ALUResult;
  logic [3:0]  ALUControl;

  int n_cmp = 0;
  int n_bad = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl), .out_valid(out_valid),
    .out_ready(out_ready), .ALUResult(ALUResult), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op, measure accept-to-out_valid latency, check the result,
  // then let the handshake complete (out_ready is expected high).
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic [31:0] exp_res,
                        input int exp_lat, input logic exp_ill);
    int lat;
    SrcA = a; SrcB = b; ALUControl = op; in_valid = 1'b1;
    chk({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    SrcA = 32'hDEAD_BEEF; SrcB = 32'h0BAD_F00D;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, ALUResult, exp_res);
    chk({tag, "_zero"}, zero, (exp_res == 32'h0));
    chk({tag, "_ill"}, illegal, exp_ill);
    @(posedge clk); #1;
    chk({tag, "_idle"}, in_ready, 1);
  endtask

  initial begin
    bit seen;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    SrcA = '0; SrcB = '0; ALUControl = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_res", ALUResult, 0);
    chk("rst_zero", zero, 1);
    chk("rst_ill", illegal, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("add_ovf", 32'h7FFF_FFFF, 32'h1, 4'b0000, 32'h8000_0000, 1, 0);
    run_op("sub_eq",  32'd5, 32'd5, 4'b0001, 32'h0, 1, 0);
    run_op("slt",     32'hFFFF_FFFF, 32'h1, 4'b0101, 32'h1, 1, 0);
    run_op("sltu",    32'hFFFF_FFFF, 32'h1, 4'b0110, 32'h0, 1, 0);
    run_op("slt_ovf", 32'h7FFF_FFFF, 32'h8000_0000, 4'b0101, 32'h0, 1, 0);
    run_op("and",     32'h0000_F0F0, 32'h0000_FF00, 4'b0010, 32'h0000_F000, 1, 0);
    run_op("or",      32'h0000_F0F0, 32'h0000_FF00, 4'b0011, 32'h0000_FFF0, 1, 0);
    run_op("xor",     32'h0000_F0F0, 32'h0000_FF00, 4'b0100, 32'h0000_0FF0, 1, 0);
    run_op("sra31",   32'h8000_0000, 32'd31, 4'b1010, 32'hFFFF_FFFF, 32, 0);
    run_op("srl4",    32'h8000_0000, 32'd4, 4'b1001, 32'h0800_0000, 5, 0);
    run_op("sll0",    32'h0000_1234, 32'h0000_0100, 4'b1000, 32'h0000_1234, 1, 0);
    run_op("sll2",    32'h0000_0003, 32'h0000_0102, 4'b1000, 32'h0000_000C, 3, 0);
`ifdef ALU_MUL_EN
    run_op("mul",     32'h0001_0001, 32'h0001_0001, 4'b1100, 32'h0002_0001, 33, 0);
`else
    run_op("mul_off", 32'h0001_0001, 32'h0001_0001, 4'b1100, 32'h0, 1, 1);
`endif
    run_op("bad_op",  32'h1234_5678, 32'h1, 4'b0111, 32'h0, 1, 1);

    // Back-pressure: result must stay put while a second op is offered.
    out_ready = 1'b0;
    SrcA = 32'd3; SrcB = 32'd4; ALUControl = 4'b0000; in_valid = 1'b1;
    @(posedge clk); #1;
    SrcA = 32'd100; SrcB = 32'd200;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_res", ALUResult, 32'd7);
      chk("bp_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle", in_ready, 1);
    chk("bp_drop", out_valid, 0);
    chk("bp_hold", ALUResult, 32'd7);
    @(posedge clk); #1;
    chk("bp_noacc", out_valid, 0);

    // Reset in the middle of a long shift, with a competing in_valid.
    SrcA = 32'hFFFF_0000; SrcB = 32'd20; ALUControl = 4'b1001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    SrcA = 32'd9; SrcB = 32'd9; ALUControl = 4'b0000; in_valid = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    chk("rstmid_valid", out_valid, 0);
    chk("rstmid_ready", in_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("rstmid_stale", seen, 0);
    run_op("add_after", 32'd1, 32'd1, 4'b0000, 32'd2, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Multi-cycle, handshaked integer ALU that succeeds the single-cycle combinational ALU in the RISC-V datapath. It is parametrised in width. It adds XOR, signed and unsigned set-less-than, iterative shifts and an optional iterative multiply. It latches operands on a valid/ready handshake, computes over one or more cycles, and holds a registered result until the consumer accepts it. It sits between the register-read stage and writeback in the multi-cycle core.

## Interface
Parameters:
- WIDTH, 32: operand/result width; legal range WIDTH ≥ 2. SHW = $clog2(WIDTH).

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  ALU can accept an op; high only in IDLE.
- SrcA  in  WIDTH  operand A.
- SrcB  in  WIDTH  operand B; SrcB[SHW-1:0] is the shift amount.
- ALUControl  in  4  op select (see Operation).
- out_valid  out  1  ALUResult/zero valid.
- out_ready  in  1  consumer accepts the result.
- ALUResult  out  WIDTH  registered result.
- zero  out  1  high when ALUResult == 0. This is a full-width compare, not a sign-bit test.
- illegal  out  1  registered; high alongside out_valid when the op code is unsupported.

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch SrcA, SrcB and ALUControl. Go to DONE for single-cycle ops and unsupported codes; go to BUSY for shift/mul.
  - BUSY: iterate. Go to DONE when the iteration count reaches 0.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Operands are captured at accept. Input changes after accept are ignored.
- ALUControl encoding:
  - 0000 ADD: A+B.
  - 0001 SUB: A+~B+1.
  - 0010 AND.
  - 0011 OR.
  - 0100 XOR.
  - 0101 SLT: signed A<B → {0…,1}, else 0. Computed from the SUB result sign XOR overflow.
  - 0110 SLTU: unsigned A<B.
  - 1000 SLL, 1001 SRL, 1010 SRA: shift one bit per BUSY cycle, count = SrcB[SHW-1:0].
  - 1100 MUL: shift-add, WIDTH iterations; low WIDTH bits of the product. Present only under ALU_MUL_EN.
  - All other codes: ALUResult=0, illegal=1, zero=1.
- All arithmetic is modulo 2^WIDTH. Overflow is not flagged except where used internally for SLT.
- Shift amount 0: BUSY is skipped; the result is A unchanged and goes IDLE→DONE directly.
- SRA replicates A[WIDTH-1] on each step. SRL and SLL fill with 0.
- ALUResult, zero and illegal are updated only on the IDLE→DONE or BUSY→DONE transition. They hold their values through IDLE until the next completion.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, ALUResult=0, zero=1, illegal=0, iteration counter=0.
- Latency (accept edge to first out_valid cycle):
  - Single-cycle ops: 1 cycle.
  - Shifts: 1+shamt cycles.
  - MUL: WIDTH+1 cycles.
- Throughput: one op per (latency+1) cycles minimum. IDLE always occupies one cycle after the DONE handshake; there is no accept in DONE.
- out_valid stays high and ALUResult stays stable until out_ready is seen. Back-pressure of any length is legal.
- in_valid while not IDLE is ignored (in_ready=0). The producer must hold the op.
- reset during BUSY or DONE: next cycle state=IDLE, out_valid=0, and the pending result is discarded. Reset has priority over every handshake.
- in_valid and reset in the same cycle: reset wins; nothing is accepted.

## Configuration
- ALU_MUL_EN defined: 1100 performs the iterative multiply. The WIDTH-bit accumulator and multiplier shift registers are instantiated.
- ALU_MUL_EN undefined: 1100 is an unsupported code (result 0, illegal=1, latency 1). No multiply hardware is built.

## Test plan
- Reset then ADD 0x7FFFFFFF+1 with out_ready=1 → out_valid 1 cycle after accept; ALUResult=0x80000000, zero=0, illegal=0.
- SUB 5-5 → ALUResult=0, zero=1. SLT 0xFFFFFFFF vs 1 → 1. SLTU same operands → 0.
- SRA 0x80000000 by 31 → out_valid 32 cycles after accept, ALUResult=0xFFFFFFFF. SLL by 0 → latency 1, result=A.
- ADD 3+4 with out_ready held low 10 cycles → out_valid and ALUResult=7 stable throughout; in_ready=0 and a concurrent in_valid is ignored. Return to IDLE 1 cycle after out_ready.
- ALU_MUL_EN: MUL 0x0001_0001×0x0001_0001 → ALUResult=0x0002_0001 after 33 cycles. Without the macro: code 1100 → ALUResult=0, illegal=1, latency 1.
- Reset asserted mid-SRL (shamt 20, cycle 5) → next cycle out_valid=0, in_ready=1, no result ever emitted for that op. A following ADD 1+1 → 2.
